// File: rtl/serial_deserializer.sv
// Serial-in/parallel-out receiver: framed MSB- or LSB-first bit stream -> WIDTH-bit word on a valid/ready port.
// Optional even-parity trailer bit and o_parity_err output when SERIAL_DESERIALIZER_PARITY_EN is defined.
module serial_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_ser_valid,
  input  logic             i_ser_data,
  input  logic             i_frame_start,
  input  logic             i_msb_first,
  output logic [WIDTH-1:0] o_par_data,
  output logic             o_par_valid,
  input  logic             i_par_ready,
  output logic             o_overrun,
  output logic             o_busy,
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  output logic             o_parity_err,
`endif
  output logic [1:0]       o_state
);

  // Handshake: a word transfers on any rising edge where o_par_valid & i_par_ready;
  // o_par_data/o_par_valid never change while o_par_valid=1 and i_par_ready=0.

`ifdef SERIAL_DESERIALIZER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_par_data;
  logic             r_par_valid;
  logic             r_overrun;
  logic             r_msb_first;

  logic             w_start;
  logic             w_dir;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_next_shreg;
  logic [WIDTH-1:0] w_final;
  logic             w_last;
  logic             w_handshake;
  logic             w_take_start;
  logic             w_take_data;
  logic             w_complete;

  assign w_start     = i_ser_valid & i_frame_start;
  assign w_handshake = r_par_valid & i_par_ready;
  assign w_last      = (r_count == CW'(NBITS - 1));
  // A frame start uses the incoming direction and a clean register.
  assign w_dir        = w_start ? i_msb_first : r_msb_first;
  assign w_base       = w_start ? '0 : r_shreg;
  assign w_next_shreg = w_dir ? {w_base[WIDTH-2:0], i_ser_data}
                              : {i_ser_data, w_base[WIDTH-1:1]};

  assign w_take_start = w_start & ((r_state != FULL) | w_handshake);
  assign w_take_data  = (r_state == SHIFT) & i_ser_valid & ~i_frame_start & ~w_last;
  assign w_complete   = (r_state == SHIFT) & i_ser_valid & ~i_frame_start & w_last;

`ifdef SERIAL_DESERIALIZER_PARITY_EN
  // Final bit is parity, so the word is already complete in the register.
  assign w_final = r_shreg;
`else
  assign w_final = w_next_shreg;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_shreg     <= '0;
      r_par_data  <= '0;
      r_par_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_msb_first <= 1'b1;
    end else begin
      r_overrun <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_take_start) begin
            r_msb_first <= i_msb_first;
            r_shreg     <= w_next_shreg;
            r_count     <= CW'(1);
            r_state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_take_start) begin
            r_msb_first <= i_msb_first;
            r_shreg     <= w_next_shreg;
            r_count     <= CW'(1);
          end else if (w_take_data) begin
            r_shreg <= w_next_shreg;
            r_count <= r_count + CW'(1);
          end else if (w_complete) begin
            r_par_data  <= w_final;
            r_par_valid <= 1'b1;
            r_count     <= '0;
            r_state     <= FULL;
          end
        end
        FULL: begin
          if (w_handshake) begin
            r_par_valid <= 1'b0;
            if (w_take_start) begin
              r_msb_first <= i_msb_first;
              r_shreg     <= w_next_shreg;
              r_count     <= CW'(1);
              r_state     <= SHIFT;
            end else begin
              r_state <= IDLE;
            end
          end else if (i_ser_valid) begin
            r_overrun <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_DESERIALIZER_PARITY_EN
  logic r_parity_acc;
  logic r_parity_err;

  // Running XOR of data bits; the error flag folds in the parity bit at completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_parity_acc <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_take_start)
        r_parity_acc <= i_ser_data;
      else if (w_take_data)
        r_parity_acc <= r_parity_acc ^ i_ser_data;

      if (w_complete)
        r_parity_err <= r_parity_acc ^ i_ser_data;
      else if ((r_state == FULL) && w_handshake)
        r_parity_err <= 1'b0;
    end
  end

  assign o_parity_err = r_parity_err;
`endif

  assign o_par_data  = r_par_data;
  assign o_par_valid = r_par_valid;
  assign o_overrun   = r_overrun;
  assign o_busy      = (r_state == SHIFT);
  assign o_state     = r_state;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: table of frames plus hand-written overrun, restart,
// back-to-back, reset and (with SERIAL_DESERIALIZER_PARITY_EN) parity sequences.
module tb_serial_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_ser_valid = 1'b0;
  logic         i_ser_data = 1'b0;
  logic         i_frame_start = 1'b0;
  logic         i_msb_first = 1'b0;
  logic         i_par_ready = 1'b0;
  logic [W-1:0] o_par_data;
  logic         o_par_valid;
  logic         o_overrun;
  logic         o_busy;
  logic [1:0]   o_state;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  logic         o_parity_err;
`endif

  int errors = 0;
  int checks = 0;

  serial_deserializer #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_ser_valid  (i_ser_valid),
    .i_ser_data   (i_ser_data),
    .i_frame_start(i_frame_start),
    .i_msb_first  (i_msb_first),
    .o_par_data   (o_par_data),
    .o_par_valid  (o_par_valid),
    .i_par_ready  (i_par_ready),
    .o_overrun    (o_overrun),
    .o_busy       (o_busy),
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    .o_parity_err (o_parity_err),
`endif
    .o_state      (o_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle from a negedge; returns at the next negedge with outputs settled.
  task automatic step(input logic v, input logic d, input logic fs, input logic msb, input logic rdy);
    i_ser_valid   = v;
    i_ser_data    = d;
    i_frame_start = fs;
    i_msb_first   = msb;
    i_par_ready   = rdy;
    @(negedge clk);
  endtask

  // seq[W-1] is the first bit on the wire.
  task automatic send_frame(input logic [W-1:0] seq, input logic msb, input logic gap,
                            input logic rdy_first, input logic bad_par,
                            input logic [W-1:0] exp, input string name);
    for (int i = 0; i < W; i++) begin
      step(1'b1, seq[W-1-i], (i == 0), msb, rdy_first && (i == 0));
      if (i == 0) begin
        check({name, " busy_first"}, o_busy, 1);
        if (rdy_first) check({name, " retired"}, o_par_valid, 0);
      end
      if (gap && i == 3) begin
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check({name, " busy_gap"}, o_busy, 1);
      end
    end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    step(1'b1, (^seq) ^ bad_par, 1'b0, msb, 1'b0);
    check({name, " parity_err"}, o_parity_err, bad_par);
`else
    if (bad_par) $display("note: parity ignored in this build");
`endif
    check({name, " valid"}, o_par_valid, 1);
    check({name, " data"}, o_par_data, exp);
    check({name, " busy_done"}, o_busy, 0);
    check({name, " overrun"}, o_overrun, 0);
    check({name, " state"}, o_state, 2);
  endtask

  task automatic retire(input string name);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check({name, " retire_valid"}, o_par_valid, 0);
    check({name, " retire_state"}, o_state, 0);
    check({name, " retire_busy"}, o_busy, 0);
  endtask

  typedef struct {
    logic [W-1:0] seq;
    logic         msb;
    logic         gap;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{seq: 8'hC1, msb: 1'b1, gap: 1'b0, exp: 8'hC1};
    vecs[1] = '{seq: 8'hC1, msb: 1'b0, gap: 1'b0, exp: 8'h83};
    vecs[2] = '{seq: 8'hA5, msb: 1'b1, gap: 1'b1, exp: 8'hA5};
    vecs[3] = '{seq: 8'h12, msb: 1'b0, gap: 1'b0, exp: 8'h48};
    vecs[4] = '{seq: 8'hF0, msb: 1'b0, gap: 1'b1, exp: 8'h0F};
    vecs[5] = '{seq: 8'h80, msb: 1'b0, gap: 1'b0, exp: 8'h01};
    vecs[6] = '{seq: 8'hFF, msb: 1'b1, gap: 1'b0, exp: 8'hFF};
    vecs[7] = '{seq: 8'h01, msb: 1'b1, gap: 1'b1, exp: 8'h01};

    #1;
    check("reset valid", o_par_valid, 0);
    check("reset data", o_par_data, 0);
    check("reset busy", o_busy, 0);
    check("reset overrun", o_overrun, 0);
    check("reset state", o_state, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].seq, vecs[v].msb, vecs[v].gap, 1'b0, 1'b0, vecs[v].exp, $sformatf("vec%0d", v));
      retire($sformatf("vec%0d", v));
    end

    // Stray bits in IDLE are ignored silently.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("idle_ignore busy", o_busy, 0);
    check("idle_ignore overrun", o_overrun, 0);
    check("idle_ignore valid", o_par_valid, 0);

    // Overrun while the word is held.
    send_frame(8'hC1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC1, "ovr");
    for (int k = 0; k < 3; k++) begin
      step(1'b1, k[0], 1'b0, 1'b1, 1'b0);
      check($sformatf("ovr pulse%0d", k), o_overrun, 1);
      check($sformatf("ovr hold%0d", k), o_par_data, 8'hC1);
      check($sformatf("ovr valid%0d", k), o_par_valid, 1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr pulse_end", o_overrun, 0);
    check("ovr still_valid", o_par_valid, 1);
    retire("ovr");

    // Partial frame discarded by a new frame_start.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("restart busy", o_busy, 1);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, "restart");
    retire("restart");

    // Handshake and next frame_start in the same cycle.
    send_frame(8'hC1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC1, "b2b_first");
    send_frame(8'h96, 1'b1, 1'b0, 1'b1, 1'b0, 8'h96, "b2b_second");
    retire("b2b");

    // Asynchronous reset mid-frame after 5 bits; par_data still holds 0x96.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    i_ser_valid   = 1'b0;
    i_frame_start = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_rst valid", o_par_valid, 0);
    check("async_rst data", o_par_data, 0);
    check("async_rst busy", o_busy, 0);
    check("async_rst overrun", o_overrun, 0);
    check("async_rst state", o_state, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, "post_rst");
    retire("post_rst");

`ifdef SERIAL_DESERIALIZER_PARITY_EN
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, "par_good");
    retire("par_good");
    check("par_good cleared", o_parity_err, 0);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, "par_bad");
    retire("par_bad");
    check("par_bad cleared", o_parity_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
